// File: rtl/mult_ctrl_pkg.sv
// rtl/mult_ctrl_pkg.sv - shared constants and FSM encoding for the multiplier-sharing controller
// Purpose : operand width of the shared booth_mult core and the controller state type.
// Contents: MULT_WIDTH (core operand width), state_t (SYNC/IDLE/START/BUSY/RESP).
package mult_ctrl_pkg;

    localparam int MULT_WIDTH = 12;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// rtl/mult_share_ctrl_if.sv - request, response and core-side signal bundle of mult_share_ctrl
// Purpose : groups every non-clock/reset signal of the controller.
// Signals : req_valid/req_ready/req_a/req_b  per-requester operand channel (packed i*WIDTH)
//           rsp_valid/rsp_ready/rsp_id/rsp_prod/rsp_err  single tagged response channel
//           mult_start/mult_multiplicand/mult_multiplier/mult_ready/mult_prod  core side
//           busy  controller not idle
// Modports: slave  - the controller
//           master - clients, core and parent driving/observing the controller
interface mult_share_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int WIDTH = 12
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_prod;
    logic                   rsp_err;
    logic                   mult_start;
    logic [WIDTH-1:0]       mult_multiplicand;
    logic [WIDTH-1:0]       mult_multiplier;
    logic                   mult_ready;
    logic [2*WIDTH-1:0]     mult_prod;
    logic                   busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mult_ready, mult_prod,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err,
               mult_start, mult_multiplicand, mult_multiplier, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mult_ready, mult_prod,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err,
               mult_start, mult_multiplicand, mult_multiplier, busy
    );
endinterface

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// rtl/mult_share_ctrl_rr_arbiter.sv - combinational N-way round-robin picker
// Purpose : selects the first requesting index at or after the pointer, wrapping.
// Ports   : i_req   request vector
//           i_ptr   highest-priority index this cycle
//           o_grant one-hot grant (all zero when nothing requests)
//           o_idx   binary index of the grant
//           o_any   at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);
    logic w_found;
    int   w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = (int'(i_ptr) + k) % N_REQ;
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = ID_W'(w_pos);
            end
        end
    end
endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - shares one signed 12x12 booth_mult core among N_REQ requesters
// Purpose : round-robin accepts operand pairs, sequences the core start/ready protocol and
//           returns each product tagged with its requester index; times out a silent core.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           bus  mult_share_ctrl_if.slave (request, response and core signals, busy)
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = MULT_WIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    mult_share_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_gidx;
    logic               w_any;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [N_REQ-1:0]   w_req_ready;
    logic               w_start;
    logic               w_rsp_valid;
    logic               w_core_done;
    logic               w_timeout;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = bus.req_a[i*WIDTH +: WIDTH];
                w_sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // In the first BUSY cycle mult_ready may still reflect the previous idle state
    // of the core, so it only counts once the counter has moved.
    assign w_core_done = (r_cnt != '0) && bus.mult_ready;
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_start     = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_SYNC:  if (bus.mult_ready) w_next = S_IDLE;
            S_IDLE: begin
                if (w_any) begin
                    w_req_ready = w_grant;
                    w_next      = S_START;
                end
            end
            S_START: begin
                w_start = 1'b1;
                w_next  = S_BUSY;
            end
            S_BUSY:  if (w_core_done || w_timeout) w_next = S_RESP;
            S_RESP: begin
                w_rsp_valid = 1'b1;
                // After a timeout the core state is unknown; resynchronise first.
                if (bus.rsp_ready) w_next = r_err ? S_SYNC : S_IDLE;
            end
            default: w_next = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_SYNC;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_id  <= w_gidx;
                        r_ptr <= (w_gidx == ID_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
                    end
                end
                S_START: r_cnt <= '0;
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_core_done) begin
                        r_prod <= bus.mult_prod;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_prod <= '0;
                        r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready         = w_req_ready;
    assign bus.mult_start        = w_start;
    assign bus.mult_multiplicand = r_a;
    assign bus.mult_multiplier   = r_b;
    assign bus.rsp_valid         = w_rsp_valid;
    assign bus.rsp_id            = r_id;
    assign bus.rsp_prod          = r_prod;
    assign bus.rsp_err           = r_err;
    assign bus.busy              = (r_state != S_IDLE);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - self-checking bench for mult_share_ctrl with a behavioural core
module tb_mult_share_ctrl;
    localparam int N  = 4;
    localparam int W  = 12;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_share_ctrl_if #(.N_REQ(N), .ID_W(2), .WIDTH(W)) bus ();

    mult_share_ctrl #(.N_REQ(N), .ID_W(2), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    // Core model: ready drops on start and returns 6 edges later (observed in accept cycle 8).
    logic        core_rdy   = 1'b0;
    logic        core_hold  = 1'b1;
    logic        core_stuck = 1'b0;
    int          core_cnt   = 0;
    logic [23:0] core_prod  = 24'h0;

    always @(posedge clk) begin
        if (bus.mult_start) begin
            core_rdy  <= 1'b0;
            core_cnt  <= core_stuck ? 0 : 6;
            core_prod <= 24'($signed(bus.mult_multiplicand) * $signed(bus.mult_multiplier));
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_rdy <= 1'b1;
        end else if (!core_stuck) begin
            core_rdy <= 1'b1;
        end
    end

    assign bus.mult_ready = core_rdy & ~core_hold;
    assign bus.mult_prod  = core_prod;

    function automatic logic [23:0] ref_prod(input logic [11:0] a, input logic [11:0] b);
        int sa, sb;
        sa = a[11] ? int'(a) - 4096 : int'(a);
        sb = b[11] ? int'(b) - 4096 : int'(b);
        return 24'(sa * sb);
    endfunction

    function automatic int pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < N; k++)
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic set_ops(input int id, input logic [11:0] a, input logic [11:0] b);
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
    endtask

    // Issues one request with rsp_ready high; reports timing relative to the accept cycle.
    task automatic run_op(input int id, input logic [11:0] a, input logic [11:0] b,
                          output int t_start, output int t_rsp, output logic [1:0] rid,
                          output logic [23:0] prod, output logic err);
        int n;
        t_start = -1; t_rsp = -1; rid = 2'd0; prod = 24'h0; err = 1'b0;
        @(negedge clk);
        set_ops(id, a, b);
        bus.req_valid = 4'(1 << id);
        bus.rsp_ready = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready !== 4'(1 << id) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) begin
            bus.req_valid = '0;
            return;
        end
        m_ptr = (id + 1) % N;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = '0;
            #1;
            if (bus.mult_start === 1'b1 && t_start < 0) t_start = c;
            if (bus.rsp_valid === 1'b1) begin
                t_rsp = c; rid = bus.rsp_id; prod = bus.rsp_prod; err = bus.rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit bad;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_prod !== 24'h0 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0) begin
            failures++; $display("FAIL reset_rsp_fields got prod=%h id=%0d err=%b exp 0", bus.rsp_prod, bus.rsp_id, bus.rsp_err); end
        checks++; if (bus.mult_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.mult_start); end
        checks++; if (bus.mult_multiplicand !== 12'h0 || bus.mult_multiplier !== 12'h0) begin
            failures++; $display("FAIL reset_operands got=%h/%h exp=0/0", bus.mult_multiplicand, bus.mult_multiplier); end
        bus.req_valid = 4'b0101;
        #1;
        checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.req_ready !== 4'b0 || bus.mult_start !== 1'b0 || bus.busy !== 1'b1) bad = 1;
            @(negedge clk);
        end
        checks++; if (bad) begin failures++; $display("FAIL sync_holds got activity=1 exp=0"); end
        bus.req_valid = '0;
        core_hold = 1'b0;
        bad = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (bus.busy === 1'b0) begin bad = 0; break; end
        end
        checks++; if (bad) begin failures++; $display("FAIL sync_to_idle got busy=%b exp=0", bus.busy); end
        m_ptr = 0;
    endtask

    task automatic test_single();
        int ts, tr; logic [1:0] rid; logic [23:0] p; logic e;
        run_op(0, 12'd3, 12'hFFB, ts, tr, rid, p, e);
        checks++; if (ts != 1) begin failures++; $display("FAIL single_start_cycle got=%0d exp=1", ts); end
        checks++; if (tr != 9) begin failures++; $display("FAIL single_rsp_cycle got=%0d exp=9", tr); end
        checks++; if (rid !== 2'd0 || p !== 24'hFFFFF1 || e !== 1'b0) begin
            failures++; $display("FAIL single_rsp got id=%0d prod=%h err=%b exp id=0 prod=fffff1 err=0", rid, p, e); end
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL single_after_hs got valid=%b busy=%b exp 0/0", bus.rsp_valid, bus.busy); end
        for (int k = 0; k < 6; k++) begin
            int id; logic [11:0] a, b;
            id = $urandom_range(0, N - 1); a = 12'($urandom); b = 12'($urandom);
            run_op(id, a, b, ts, tr, rid, p, e);
            checks++; if (tr != 9 || rid !== 2'(id) || p !== ref_prod(a, b) || e !== 1'b0) begin
                failures++; $display("FAIL random_op got t=%0d id=%0d prod=%h err=%b exp t=9 id=%0d prod=%h err=0",
                                     tr, rid, p, e, id, ref_prod(a, b)); end
        end
    endtask

    task automatic test_extremes();
        logic [11:0] ta[3]; logic [11:0] tb_[3]; logic [23:0] te[3];
        int ts, tr; logic [1:0] rid; logic [23:0] p; logic e;
        ta[0] = 12'h800; tb_[0] = 12'h800; te[0] = 24'h400000;
        ta[1] = 12'h7FF; tb_[1] = 12'h800; te[1] = 24'hC00800;
        ta[2] = 12'h000; tb_[2] = 12'hFFF; te[2] = 24'h000000;
        for (int k = 0; k < 3; k++) begin
            run_op(k + 1, ta[k], tb_[k], ts, tr, rid, p, e);
            checks++; if (p !== te[k] || e !== 1'b0 || rid !== 2'(k + 1)) begin
                failures++; $display("FAIL extreme_%0d got prod=%h err=%b id=%0d exp prod=%h err=0 id=%0d", k, p, e, rid, te[k], k + 1); end
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] oa[N]; logic [11:0] ob[N];
        int exp_g, t_prev, ngr, nrsp, pend_id, upd_id; logic [23:0] pend_prod; bit upd;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            oa[i] = 12'($urandom); ob[i] = 12'($urandom); set_ops(i, oa[i], ob[i]);
        end
        bus.req_valid = '1; bus.rsp_ready = 1'b1;
        ngr = 0; nrsp = 0; t_prev = -1; upd = 0; upd_id = 0; pend_id = -1; pend_prod = '0;
        for (int cyc = 0; cyc < 200 && nrsp < 6; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (upd) begin
                    oa[upd_id] = 12'($urandom); ob[upd_id] = 12'($urandom);
                    set_ops(upd_id, oa[upd_id], ob[upd_id]);
                    if (ngr == 6) bus.req_valid = '0;
                    upd = 0;
                end
            end
            #1;
            if (bus.req_ready !== 4'b0) begin
                exp_g = m_ptr;
                checks++; if (bus.req_ready !== 4'(1 << exp_g)) begin
                    failures++; $display("FAIL rr_grant got=%b exp=%b", bus.req_ready, 4'(1 << exp_g)); end
                if (t_prev >= 0) begin
                    checks++; if (cyc - t_prev != 10) begin failures++; $display("FAIL rr_spacing got=%0d exp=10", cyc - t_prev); end
                end
                t_prev = cyc; pend_id = exp_g; pend_prod = ref_prod(oa[exp_g], ob[exp_g]);
                m_ptr = (exp_g + 1) % N; ngr++; upd = 1; upd_id = exp_g;
            end
            if (bus.rsp_valid === 1'b1) begin
                checks++; if (bus.rsp_id !== 2'(pend_id) || bus.rsp_prod !== pend_prod || bus.rsp_err !== 1'b0) begin
                    failures++; $display("FAIL rr_rsp got id=%0d prod=%h err=%b exp id=%0d prod=%h err=0",
                                         bus.rsp_id, bus.rsp_prod, bus.rsp_err, pend_id, pend_prod); end
                nrsp++;
            end
        end
        checks++; if (nrsp != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", nrsp); end
    endtask

    task automatic test_random_arb();
        for (int it = 0; it < 10; it++) begin
            logic [3:0] mask; logic [11:0] oa[N]; logic [11:0] ob[N];
            int exp_g, t_first; bit done;
            @(negedge clk);
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                oa[i] = 12'($urandom); ob[i] = 12'($urandom); set_ops(i, oa[i], ob[i]);
            end
            bus.req_valid = mask; bus.rsp_ready = 1'($urandom);
            exp_g = pick(mask, m_ptr);
            #1;
            checks++; if (bus.req_ready !== 4'(1 << exp_g)) begin
                failures++; $display("FAIL arb_grant mask=%b got=%b exp=%b", mask, bus.req_ready, 4'(1 << exp_g)); end
            m_ptr = (exp_g + 1) % N;
            t_first = -1; done = 0;
            for (int c = 1; c < 60 && !done; c++) begin
                @(negedge clk);
                if (c == 1) bus.req_valid = '0;
                bus.rsp_ready = 1'($urandom);
                #1;
                if (bus.rsp_valid === 1'b1 && t_first < 0) t_first = c;
                if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                    done = 1;
                    checks++; if (bus.rsp_id !== 2'(exp_g) || bus.rsp_prod !== ref_prod(oa[exp_g], ob[exp_g]) || bus.rsp_err !== 1'b0) begin
                        failures++; $display("FAIL arb_rsp got id=%0d prod=%h err=%b exp id=%0d prod=%h err=0",
                                             bus.rsp_id, bus.rsp_prod, bus.rsp_err, exp_g, ref_prod(oa[exp_g], ob[exp_g])); end
                end
            end
            checks++; if (t_first != 9 || !done) begin failures++; $display("FAIL arb_latency got=%0d done=%0d exp=9", t_first, done); end
        end
    endtask

    task automatic test_backpressure();
        int r1, r2, n; logic [11:0] a1, b1, a2, b2; logic [1:0] sid; logic [23:0] sprod; logic serr;
        bit unstable, leak;
        r1 = $urandom_range(0, N - 1); r2 = (r1 + $urandom_range(1, N - 1)) % N;
        a1 = 12'($urandom); b1 = 12'($urandom); a2 = 12'($urandom); b2 = 12'($urandom);
        @(negedge clk);
        set_ops(r1, a1, b1); bus.req_valid = 4'(1 << r1); bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'(1 << r1)) begin failures++; $display("FAIL bp_grant1 got=%b exp=%b", bus.req_ready, 4'(1 << r1)); end
        m_ptr = (r1 + 1) % N;
        @(negedge clk); bus.req_valid = '0; #1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
        sid = bus.rsp_id; sprod = bus.rsp_prod; serr = bus.rsp_err;
        checks++; if (n >= 40 || sid !== 2'(r1) || sprod !== ref_prod(a1, b1) || serr !== 1'b0) begin
            failures++; $display("FAIL bp_rsp got id=%0d prod=%h err=%b exp id=%0d prod=%h err=0", sid, sprod, serr, r1, ref_prod(a1, b1)); end
        set_ops(r2, a2, b2); bus.req_valid = 4'(1 << r2);
        unstable = 0; leak = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== sid || bus.rsp_prod !== sprod || bus.rsp_err !== serr) unstable = 1;
            if (bus.req_ready !== 4'b0 || bus.mult_start !== 1'b0) leak = 1;
        end
        checks++; if (unstable) begin failures++; $display("FAIL bp_stable got unstable=1 exp=0"); end
        checks++; if (leak) begin failures++; $display("FAIL bp_no_grant got activity=1 exp=0"); end
        @(negedge clk); bus.rsp_ready = 1'b1; #1;
        checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL bp_hs_cycle_grant got=%b exp=0000", bus.req_ready); end
        @(negedge clk); #1;
        checks++; if (bus.req_ready !== 4'(1 << r2) || bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL bp_next_grant got=%b valid=%b exp=%b valid=0", bus.req_ready, bus.rsp_valid, 4'(1 << r2)); end
        m_ptr = (r2 + 1) % N;
        @(negedge clk); bus.req_valid = '0; #1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
        checks++; if (n >= 40 || bus.rsp_id !== 2'(r2) || bus.rsp_prod !== ref_prod(a2, b2)) begin
            failures++; $display("FAIL bp_rsp2 got id=%0d prod=%h exp id=%0d prod=%h", bus.rsp_id, bus.rsp_prod, r2, ref_prod(a2, b2)); end
    endtask

    task automatic test_reset_mid();
        int ts, tr; logic [1:0] rid; logic [23:0] p; logic e; logic [11:0] a, b; bit bad;
        @(negedge clk);
        set_ops(1, 12'($urandom), 12'($urandom)); bus.req_valid = 4'b0010; bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL rm_grant got=%b exp=0010", bus.req_ready); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = '0;
        end
        core_hold = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_ptr = 0;
        set_ops(2, 12'($urandom), 12'($urandom)); bus.req_valid = 4'b0100;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (bus.rsp_valid !== 1'b0 || bus.mult_start !== 1'b0 || bus.req_ready !== 4'b0 || bus.busy !== 1'b1) bad = 1;
            @(negedge clk);
        end
        checks++; if (bad) begin failures++; $display("FAIL rm_quiet got activity=1 exp=0"); end
        bus.req_valid = '0;
        core_hold = 1'b0;
        a = 12'($urandom); b = 12'($urandom);
        run_op(2, a, b, ts, tr, rid, p, e);
        checks++; if (ts != 1 || tr != 9 || rid !== 2'd2 || p !== ref_prod(a, b) || e !== 1'b0) begin
            failures++; $display("FAIL rm_after got ts=%0d tr=%0d id=%0d prod=%h err=%b exp 1/9/2/%h/0", ts, tr, rid, p, e, ref_prod(a, b)); end
    endtask

    task automatic test_timeout();
        int ts, tr; logic [1:0] rid; logic [23:0] p; logic e; logic [11:0] a, b; bit bad;
        core_stuck = 1'b1;
        run_op(3, 12'($urandom), 12'($urandom), ts, tr, rid, p, e);
        checks++; if (tr != 2 + TO) begin failures++; $display("FAIL to_cycle got=%0d exp=%0d", tr, 2 + TO); end
        checks++; if (e !== 1'b1 || p !== 24'h0 || rid !== 2'd3) begin
            failures++; $display("FAIL to_rsp got err=%b prod=%h id=%0d exp err=1 prod=0 id=3", e, p, rid); end
        @(negedge clk);
        set_ops(0, 12'd5, 12'd7); bus.req_valid = 4'b0001;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.req_ready !== 4'b0 || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++; if (bad) begin failures++; $display("FAIL to_sync got activity=1 exp=0"); end
        bus.req_valid = '0;
        core_stuck = 1'b0;
        a = 12'($urandom); b = 12'($urandom);
        run_op(0, a, b, ts, tr, rid, p, e);
        checks++; if (tr != 9 || p !== ref_prod(a, b) || e !== 1'b0) begin
            failures++; $display("FAIL to_recover got tr=%0d prod=%h err=%b exp 9/%h/0", tr, p, e, ref_prod(a, b)); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_extremes();
        test_round_robin();
        test_random_arb();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
